// File: rtl/gcd_requester_if.sv
// Request/response streams and GCD core load interface for gcd_requester.
// master: the requesting environment plus the core it drives.
// slave: the gcd_requester front end itself.
interface gcd_requester_if #(
  parameter int XLEN = 16,
  parameter int CYCW = 8
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] req_a_i;
  logic [XLEN-1:0] req_b_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_gcd_o;
  logic            resp_err_o;
  logic [CYCW-1:0] resp_cycles_o;
  logic            core_ld_o;
  logic [XLEN-1:0] core_a_o;
  logic [XLEN-1:0] core_b_o;
  logic            core_clr_o;
  logic            core_done_i;
  logic [XLEN-1:0] core_gcd_i;

  modport master (
    output req_valid_i, req_a_i, req_b_i, resp_ready_i, core_done_i, core_gcd_i,
    input  req_ready_o, resp_valid_o, resp_gcd_o, resp_err_o, resp_cycles_o,
           core_ld_o, core_a_o, core_b_o, core_clr_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, resp_ready_i, core_done_i, core_gcd_i,
    output req_ready_o, resp_valid_o, resp_gcd_o, resp_err_o, resp_cycles_o,
           core_ld_o, core_a_o, core_b_o, core_clr_o
  );
endinterface

// File: rtl/gcd_requester.sv
// Initiator-side front end for the GCD core: accepts operand pairs,
// short-circuits zero operands, loads the core, waits for DONE with a
// timeout, and returns gcd/err/cycle-count on a response stream.
module gcd_requester #(
  parameter int XLEN    = 16,
  parameter int TIMEOUT = 255,
  parameter int CYCW    = 8
) (
  input  logic            clk,
  input  logic            resetn,
  gcd_requester_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CYCW-1:0] TO = CYCW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] gcd_q, gcd_d;
  logic            err_q, err_d;
  logic            clr_q, clr_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic [CYCW-1:0] cnt_q, cnt_d;
  logic [CYCW-1:0] cnt_inc;

  // Saturating increment; the reported cycle count is the number of WAIT
  // cycles consumed including the one in which done/timeout is decided.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (bus.req_a_i == '0 && bus.req_b_i == '0) begin
            gcd_d   = '0;
            err_d   = 1'b1;
            cyc_d   = '0;
            state_d = RESP;
          end else if (bus.req_a_i == '0) begin
            gcd_d   = bus.req_b_i;
            err_d   = 1'b0;
            cyc_d   = '0;
            state_d = RESP;
          end else if (bus.req_b_i == '0) begin
            gcd_d   = bus.req_a_i;
            err_d   = 1'b0;
            cyc_d   = '0;
            state_d = RESP;
          end else begin
            a_d     = bus.req_a_i;
            b_d     = bus.req_b_i;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (bus.core_done_i) begin
          gcd_d   = bus.core_gcd_i;
          err_d   = 1'b0;
          cyc_d   = cnt_inc;
          state_d = RESP;
        end else if (cnt_inc == TO) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          cyc_d   = TO;
          clr_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.resp_valid_o  = (state_q == RESP);
  assign bus.resp_gcd_o    = gcd_q;
  assign bus.resp_err_o    = err_q;
  assign bus.resp_cycles_o = cyc_q;
  assign bus.core_ld_o     = (state_q == ISSUE);
  assign bus.core_a_o      = a_q;
  assign bus.core_b_o      = b_q;
  assign bus.core_clr_o    = clr_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester with a behavioural GCD core model.
module tb_gcd_requester;
  localparam int XLEN    = 16;
  localparam int CYCW    = 8;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  gcd_requester_if #(.XLEN(XLEN), .CYCW(CYCW)) bus ();

  gcd_requester #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CYCW(CYCW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural core: done `cur_delay` cycles after the load pulse; negative = never.
  int              cur_delay = 0;
  int              rem;
  logic            busy, never_q;
  logic [XLEN-1:0] res;

  function automatic logic [XLEN-1:0] euclid(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic [XLEN-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model state.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy    <= 1'b0;
      never_q <= 1'b0;
      rem     <= 0;
      res     <= '0;
    end else if (bus.core_ld_o) begin
      busy    <= 1'b1;
      never_q <= (cur_delay < 0);
      rem     <= cur_delay;
      res     <= euclid(bus.core_a_o, bus.core_b_o);
    end else if (bus.core_clr_o) begin
      busy <= 1'b0;
    end else if (busy && rem > 0) begin
      rem <= rem - 1;
    end
  end

  assign bus.core_done_i = busy && !never_q && (rem == 0);
  assign bus.core_gcd_i  = bus.core_done_i ? res : 16'hDEAD;

  // Pulse counters and operand capture at the load pulse.
  int              ld_cnt = 0;
  int              clr_cnt = 0;
  logic [XLEN-1:0] ld_a, ld_b;
  always @(posedge clk) begin
    if (resetn) begin
      if (bus.core_ld_o) begin
        ld_cnt <= ld_cnt + 1;
        ld_a   <= bus.core_a_o;
        ld_b   <= bus.core_b_o;
      end
      if (bus.core_clr_o) clr_cnt <= clr_cnt + 1;
    end
  end

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int              delay;
    logic [XLEN-1:0] gcd;
    logic            err;
    logic [CYCW-1:0] cyc;
    int              ld;
    int              clr;
  } vec_t;

  vec_t vecs[8];

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"},  bus.req_ready_o, 1);
    chk({tag, "_resp_valid"}, bus.resp_valid_o, 0);
    chk({tag, "_gcd"},        bus.resp_gcd_o, 0);
    chk({tag, "_err"},        bus.resp_err_o, 0);
    chk({tag, "_cycles"},     bus.resp_cycles_o, 0);
    chk({tag, "_ld"},         bus.core_ld_o, 0);
    chk({tag, "_clr"},        bus.core_clr_o, 0);
    chk({tag, "_core_a"},     bus.core_a_o, 0);
    chk({tag, "_core_b"},     bus.core_b_o, 0);
  endtask

  task automatic send_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
    @(negedge clk);
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_valid_i = 1'b1;
    chk({tag, "_req_ready"}, bus.req_ready_o, 1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  // Returns the number of clock edges from the accepting edge to resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int ld0, clr0, lat;
    ld0 = ld_cnt;
    clr0 = clr_cnt;
    cur_delay = v.delay;
    send_req(v.a, v.b, tag);
    wait_resp(lat);
    chk({tag, "_resp_valid"}, bus.resp_valid_o, 1);
    chk({tag, "_latency"},    lat, (v.ld != 0) ? int'(v.cyc) + 2 : 1);
    chk({tag, "_gcd"},        bus.resp_gcd_o, v.gcd);
    chk({tag, "_err"},        bus.resp_err_o, v.err);
    chk({tag, "_cycles"},     bus.resp_cycles_o, v.cyc);
    chk({tag, "_busy_ready"}, bus.req_ready_o, 0);
    if (v.ld != 0) begin
      chk({tag, "_ld_a"}, ld_a, v.a);
      chk({tag, "_ld_b"}, ld_b, v.b);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    chk({tag, "_drop_valid"}, bus.resp_valid_o, 0);
    chk({tag, "_idle_ready"}, bus.req_ready_o, 1);
    chk({tag, "_ld_pulses"},  ld_cnt - ld0, v.ld);
    chk({tag, "_clr_pulses"}, clr_cnt - clr0, v.clr);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (time limit reached)");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, ld0;
    logic ok;

    //        a       b       delay gcd   err   cyc   ld clr
    vecs[0] = '{16'd48,    16'd18,  10,  16'd6,   1'b0, 8'd11,  1, 0};
    vecs[1] = '{16'd0,     16'd35,  0,   16'd35,  1'b0, 8'd0,   0, 0};
    vecs[2] = '{16'd35,    16'd0,   0,   16'd35,  1'b0, 8'd0,   0, 0};
    vecs[3] = '{16'd0,     16'd0,   0,   16'd0,   1'b1, 8'd0,   0, 0};
    vecs[4] = '{16'd21,    16'd14,  3,   16'd7,   1'b0, 8'd4,   1, 0};
    vecs[5] = '{16'd65535, 16'd255, 0,   16'd255, 1'b0, 8'd1,   1, 0};
    vecs[6] = '{16'd100,   16'd75,  254, 16'd25,  1'b0, 8'd255, 1, 0};
    vecs[7] = '{16'd9,     16'd6,   -1,  16'd0,   1'b1, 8'd255, 1, 1};

    bus.req_valid_i  = 1'b0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.resp_ready_i = 1'b0;

    #23;
    check_reset("por");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: response held 20 cycles, a competing request is not taken.
    ld0 = ld_cnt;
    cur_delay = 10;
    send_req(16'd48, 16'd18, "bp");
    wait_resp(lat);
    chk("bp_valid", bus.resp_valid_o, 1);
    bus.req_a_i     = 16'd5;
    bus.req_b_i     = 16'd0;
    bus.req_valid_i = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(bus.resp_valid_o && bus.resp_gcd_o == 16'd6 && !bus.resp_err_o &&
            bus.resp_cycles_o == 8'd11 && !bus.req_ready_o)) ok = 1'b0;
    end
    chk("bp_hold", ok, 1);
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_no_extra_resp", bus.resp_valid_o, 0);
    chk("bp_ld_pulses", ld_cnt - ld0, 1);
    chk("bp_idle_ready", bus.req_ready_o, 1);

    // Reset during WAIT, then a fresh transaction.
    cur_delay = 10;
    send_req(16'd48, 16'd18, "rst");
    repeat (5) @(negedge clk);
    chk("rst_in_wait_ready", bus.req_ready_o, 0);
    #2 resetn = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    run_vec(vecs[4], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
